// File: rtl/dm_if.sv
// dm_if: load/store request and completion signals between the MEM stage and the data-memory responder
interface dm_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ready;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    modport master(output req, we, addr, wdata, be, input ready, done, rdata, err);
    modport slave(input req, we, addr, wdata, be, output ready, done, rdata, err);
endinterface

// File: rtl/dm_responder.sv
// dm_responder: data-memory responder with programmable wait states and byte-lane stores
module dm_responder #(
    parameter int NMEM = 128,
    parameter int WAIT = 2
) (
    input logic clk,
    input logic rst,
    dm_if.slave bus
);
    localparam int AW = $clog2(NMEM);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        done_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] mem [NMEM];
    logic        src_we;
    logic [31:0] src_addr;
    logic        src_err;
    logic [31:0] src_rdata;
    assign bus.ready = state_q == S_IDLE;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
    // response terms: the live bus when a zero-wait accept enters RESP straight from IDLE, else the captured request
    always_comb begin
        src_we    = state_q == S_IDLE ? bus.we : we_q;
        src_addr  = state_q == S_IDLE ? bus.addr : addr_q;
        src_err   = src_addr[1:0] != 2'd0 || src_addr >= 32'(4 * NMEM);
        src_rdata = src_err || src_we ? 32'd0 : mem[src_addr[AW+1:2]];
    end
    // request FSM; done/err/rdata are registered on entry to RESP and cleared on leaving it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.req) begin
                    we_q    <= bus.we;
                    addr_q  <= bus.addr;
                    wdata_q <= bus.wdata;
                    be_q    <= bus.be;
                    if (WAIT == 0) begin
                        state_q <= S_RESP;
                        done_q  <= 1'b1;
                        err_q   <= src_err;
                        rdata_q <= src_rdata;
                    end else begin
                        state_q <= S_WAIT;
                        cnt_q   <= 4'(WAIT - 1);
                    end
                end
                S_WAIT: if (cnt_q == 4'd0) begin
                    state_q <= S_RESP;
                    done_q  <= 1'b1;
                    err_q   <= src_err;
                    rdata_q <= src_rdata;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= 32'd0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
    // store commits lane by lane on the edge leaving RESP; the array itself is never reset
    always_ff @(posedge clk) begin
        if (state_q == S_RESP && we_q && !err_q)
            for (int i = 0; i < 4; i++)
                if (be_q[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= wdata_q[8*i +: 8];
    end
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed checks of the responder with WAIT=2 and a WAIT=0 build
module tb_dm_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    dm_if a_if();
    dm_if b_if();
    dm_responder #(.NMEM(128), .WAIT(2)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
    dm_responder #(.NMEM(128), .WAIT(0)) dut_b (.clk(clk), .rst(rst), .bus(b_if));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one request on the WAIT=2 instance; lat counts falling edges from accept to done
    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                        output logic [31:0] rd, output logic er, output int lat, output int rdy_hi);
        @(negedge clk);
        check("ready_before_req", {31'd0, a_if.ready}, 32'd1);
        a_if.req = 1'b1;
        a_if.we = w;
        a_if.addr = a;
        a_if.wdata = d;
        a_if.be = b;
        @(posedge clk);
        #1 a_if.req = 1'b0;
        lat = 0;
        rdy_hi = 0;
        rd = 32'd0;
        er = 1'b0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clk);
            if (a_if.ready) rdy_hi++;
            if (a_if.done) begin
                lat = i;
                rd = a_if.rdata;
                er = a_if.err;
            end
        end
    endtask

    logic [31:0] rd;
    logic er;
    int lat;
    int rh;
    int cnt;

    initial begin
        a_if.req = 1'b0; a_if.we = 1'b0; a_if.addr = 32'd0; a_if.wdata = 32'd0; a_if.be = 4'd0;
        b_if.req = 1'b0; b_if.we = 1'b0; b_if.addr = 32'd0; b_if.wdata = 32'd0; b_if.be = 4'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_ready", {31'd0, a_if.ready}, 32'd1);
            check("rst_done", {31'd0, a_if.done}, 32'd0);
            check("rst_rdata", a_if.rdata, 32'd0);
            check("rst_err", {31'd0, a_if.err}, 32'd0);
        end
        xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat, rh);
        check("st_lat", lat, 32'd3);
        check("st_ready_low", rh, 32'd0);
        check("st_err", {31'd0, er}, 32'd0);
        check("st_rdata", rd, 32'd0);
        xact(1'b0, 32'h10, 32'd0, 4'h0, rd, er, lat, rh);
        check("ld_lat", lat, 32'd3);
        check("ld_rdata", rd, 32'hDEADBEEF);
        check("ld_err", {31'd0, er}, 32'd0);
        xact(1'b1, 32'h10, 32'h11223344, 4'b0101, rd, er, lat, rh);
        xact(1'b0, 32'h10, 32'd0, 4'h0, rd, er, lat, rh);
        check("lane_rdata", rd, 32'hDE22BE44);
        xact(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, rd, er, lat, rh);
        check("be0_lat", lat, 32'd3);
        xact(1'b0, 32'h10, 32'd0, 4'h0, rd, er, lat, rh);
        check("be0_rdata", rd, 32'hDE22BE44);
        xact(1'b0, 32'h13, 32'd0, 4'h0, rd, er, lat, rh);
        check("mis_lat", lat, 32'd3);
        check("mis_err", {31'd0, er}, 32'd1);
        check("mis_rdata", rd, 32'd0);
        xact(1'b1, 32'h11, 32'h55555555, 4'hF, rd, er, lat, rh);
        check("mis_st_err", {31'd0, er}, 32'd1);
        xact(1'b0, 32'h10, 32'd0, 4'h0, rd, er, lat, rh);
        check("mis_st_nowrite", rd, 32'hDE22BE44);
        xact(1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, rd, er, lat, rh);
        xact(1'b1, 32'h200, 32'h01010101, 4'hF, rd, er, lat, rh);
        check("oor_err", {31'd0, er}, 32'd1);
        check("oor_lat", lat, 32'd3);
        xact(1'b0, 32'h0, 32'd0, 4'h0, rd, er, lat, rh);
        check("oor_nowrite", rd, 32'hA5A5A5A5);
        xact(1'b0, 32'h1FC, 32'd0, 4'h0, rd, er, lat, rh);
        check("top_word_err", {31'd0, er}, 32'd0);
        xact(1'b1, 32'h20, 32'h12345678, 4'hF, rd, er, lat, rh);
        @(negedge clk);
        a_if.req = 1'b1; a_if.we = 1'b1; a_if.addr = 32'h20; a_if.wdata = 32'hCAFEF00D; a_if.be = 4'hF;
        @(posedge clk);
        #1 a_if.req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #2 rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (a_if.done) cnt++;
            if (i == 0) check("rst_mid_ready", {31'd0, a_if.ready}, 32'd1);
        end
        check("rst_mid_nodone", cnt, 32'd0);
        xact(1'b0, 32'h20, 32'd0, 4'h0, rd, er, lat, rh);
        check("rst_mid_rdata", rd, 32'h12345678);
        @(negedge clk);
        b_if.req = 1'b1; b_if.we = 1'b1; b_if.addr = 32'h4; b_if.wdata = 32'h0BADF00D; b_if.be = 4'hF;
        @(posedge clk);
        #1 b_if.req = 1'b0;
        @(negedge clk);
        check("w0_st_done", {31'd0, b_if.done}, 32'd1);
        @(negedge clk);
        check("w0_idle_ready", {31'd0, b_if.ready}, 32'd1);
        b_if.req = 1'b1; b_if.we = 1'b0; b_if.addr = 32'h4;
        cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("w0_done", {31'd0, b_if.done}, {31'd0, i[0]});
            check("w0_ready", {31'd0, b_if.ready}, {31'd0, ~i[0]});
            if (b_if.done) begin
                cnt++;
                check("w0_rdata", b_if.rdata, 32'h0BADF00D);
            end
        end
        b_if.req = 1'b0;
        check("w0_accepts", cnt, 32'd4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
